// File: rtl/rand_range_draw_if.sv
// Handshake and data bundle for rand_range_draw: random source, draw request and result.
interface rand_range_draw_if;
  logic [15:0] rnd_in;
  logic        req;
  logic [7:0]  range_n;
  logic        busy;
  logic        done;
  logic [7:0]  value;
  logic [3:0]  retries;
  logic        err;

  modport master (
    output rnd_in, req, range_n,
    input  busy, done, value, retries, err
  );

  modport slave (
    input  rnd_in, req, range_n,
    output busy, done, value, retries, err
  );
endinterface

// File: rtl/rand_range_draw.sv
// Draws a number in 0..N-1 from a 15-bit random word using one shared restoring divider.
// Macro RAND_REJECT_EN enables the LIMIT step and q<qmax rejection (unbiased draw).
module rand_range_draw (
  input logic               clk,
  input logic               rst_n,
  rand_range_draw_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLimit, StSample, StDiv, StCheck} state_e;

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  value_q, value_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef RAND_REJECT_EN
  logic [15:0] qmax_q, qmax_d;
  logic [3:0]  retries_q, retries_d;
`endif

  // Bit 15 of the random word is deliberately discarded.
  logic unused_rnd_msb;
  assign unused_rnd_msb = bus.rnd_in[15];

  // One restoring-division step: quo_q shifts the dividend out and the quotient in.
  logic [8:0]  trial;
  logic        trial_ge;
  logic [7:0]  step_rem;
  logic [15:0] step_quo;

  assign trial    = {rem_q, quo_q[15]};
  assign trial_ge = trial >= {1'b0, n_q};
  assign step_rem = trial_ge ? 8'(trial - {1'b0, n_q}) : trial[7:0];
  assign step_quo = {quo_q[14:0], trial_ge};

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef RAND_REJECT_EN
    qmax_d    = qmax_q;
    retries_d = retries_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          n_d   = bus.range_n;
          err_d = 1'b0;
          rem_d = 8'd0;
          cnt_d = 4'd0;
`ifdef RAND_REJECT_EN
          retries_d = 4'd0;
          quo_d     = 16'h8000;
          state_d   = StLimit;
`else
          state_d   = StSample;
`endif
        end
      end
`ifdef RAND_REJECT_EN
      StLimit: begin
        if (n_q == 8'd0) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          value_d = 8'd0;
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            qmax_d  = step_quo;
            state_d = StSample;
          end
        end
      end
`endif
      StSample: begin
`ifndef RAND_REJECT_EN
        if (n_q == 8'd0) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          value_d = 8'd0;
          state_d = StIdle;
        end else
`endif
        begin
          quo_d   = {1'b0, bus.rnd_in[14:0]};
          rem_d   = 8'd0;
          cnt_d   = 4'd0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
`ifdef RAND_REJECT_EN
        if (quo_q < qmax_q) begin
          value_d = rem_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          if (retries_q != 4'd15) begin
            retries_d = retries_q + 4'd1;
          end
          state_d = StSample;
        end
`else
        value_d = rem_q;
        done_d  = 1'b1;
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      n_q       <= 8'd0;
      rem_q     <= 8'd0;
      quo_q     <= 16'd0;
      cnt_q     <= 4'd0;
      value_q   <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef RAND_REJECT_EN
      qmax_q    <= 16'd0;
      retries_q <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef RAND_REJECT_EN
      qmax_q    <= qmax_d;
      retries_q <= retries_d;
`endif
    end
  end

  assign bus.busy  = state_q != StIdle;
  assign bus.done  = done_q;
  assign bus.value = value_q;
  assign bus.err   = err_q;
`ifdef RAND_REJECT_EN
  assign bus.retries = retries_q;
`else
  assign bus.retries = 4'd0;
`endif

endmodule

// File: doc/rand_range_draw.md
RAND_RANGE_DRAW -- requirements
Module: rand_range_draw

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 The block SHALL have: rst_n  input  1  synchronous reset, active low.
REQ-003 The block SHALL have: rnd_in  input  16  free-running random word from the 16-bit generator; bit 15 ignored; sampled value 0..32767.
REQ-004 The block SHALL have: req  input  1  draw request, level-sampled in IDLE only.
REQ-005 The block SHALL have: range_n  input  8  draw modulus N, latched when req is accepted.
REQ-006 The block SHALL have: busy  output  1  high in every state except IDLE.
REQ-007 The block SHALL have: done  output  1  one-cycle pulse marking a valid result.
REQ-008 The block SHALL have: value  output  8  drawn number in 0..N-1, held until the next done.
REQ-009 The block SHALL have: retries  output  4  rejected samples in the last draw, saturating at 15.
REQ-010 The block SHALL have: err  output  1  set with done when N==0; cleared at the next accepted req.

Function
REQ-011 States SHALL be IDLE, LIMIT, SAMPLE, DIV, CHECK; a single 16-iteration restoring divider (16-bit dividend, 8-bit divisor) SHALL be shared by LIMIT and DIV.
REQ-012 On the edge where IDLE sees req=1, the block SHALL latch range_n, clear retries and err, and go to LIMIT (to SAMPLE when REQ-030 compiles LIMIT out).
REQ-013 LIMIT SHALL compute qmax = floor(32768/N) in 16 cycles, then go to SAMPLE.
REQ-014 SAMPLE SHALL take {1'b0, rnd_in[14:0]} as the dividend in one cycle, then go to DIV.
REQ-015 DIV SHALL produce q = sample/N and r = sample mod N in exactly 16 cycles, then go to CHECK.
REQ-016 CHECK SHALL accept when q < qmax: value<=r[7:0], done=1 for one cycle, next state IDLE.
REQ-017 CHECK SHALL reject when q >= qmax: retries increments (saturating at 15), next state SAMPLE; there is no retry limit.
REQ-018 Latency from the accepting edge to the done edge SHALL be 34 cycles when the first sample is accepted; each rejection SHALL add 18 cycles.
REQ-019 When N==0, the block SHALL assert done and err on the edge after acceptance, set value=0 and go to IDLE.
REQ-020 When N==1, value SHALL always be 0 and no sample SHALL be rejected.
REQ-021 The block SHALL ignore req while busy; range_n changes during a draw SHALL have no effect.
REQ-022 When req is held high, a new draw SHALL start on the edge after done, because IDLE samples req.
REQ-023 The block SHALL never stall rnd_in; the source advances every cycle, so successive samples differ.

Reset
REQ-024 When rst_n=0 on a clock edge, the block SHALL force IDLE and clear busy, done, value, retries, err and the divider registers.
REQ-025 Reset during a draw SHALL abort the draw with no done pulse; the first draw SHALL be accepted no earlier than the edge after rst_n returns high.
REQ-026 The block SHALL have no asynchronous reset path and no initial-value reliance.

Configuration
REQ-027 RAND_REJECT_EN SHALL be the only configuration macro.
REQ-028 With RAND_REJECT_EN defined, the block SHALL implement LIMIT and the q<qmax rejection (unbiased draw).
REQ-029 With RAND_REJECT_EN defined, latency SHALL be per REQ-018.
REQ-030 With RAND_REJECT_EN undefined, LIMIT and qmax SHALL be absent, CHECK SHALL always accept (modulo draw, small bias), retries SHALL be tied to 0, and latency SHALL be exactly 18 cycles.

Verification
REQ-031 Mean-value draw: reset, rnd_in=16'h1234, N=10, req pulse -> done 34 cycles later, value=0 (4660 mod 10), retries=0, err=0.
REQ-032 Rejection: N=200 (qmax=163), rnd_in=16'h7FA0 (32672, q=163) for 20 cycles after the SAMPLE edge, then 16'h0064 -> value=100, retries=1, done at 52 cycles.
REQ-033 Bit 15 ignored: rnd_in=16'h8005, N=3 -> value=2.
REQ-034 Edge cases, run separately: N=0 -> done+err one cycle after acceptance, value=0; N=1 with rnd_in=16'h7FFF -> value=0, retries=0.
REQ-035 Reset mid-draw: drop rst_n 10 cycles into a draw -> busy=0, no done pulse, all outputs 0; a req pulsed in the same cycle as the rst_n drop is ignored.
REQ-036 RAND_REJECT_EN undefined: N=200, rnd_in=16'h7FA0 -> value=72, retries=0, done 18 cycles after acceptance.
